// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one external 16-bit SRAM port among the MIC17 decoder stages
//   (req 0 lossless decode, req 1 IDCT fetch/write, req 2 upsample/CSC).
//   The arbiter is round-robin. An owner keeps the port for a burst of grants.
//   The burst is capped at MAX_BURST cycles, but only while another requester waits.
//   The SRAM command is registered. Read data is routed back to the requester
//   that issued the read, using a tag shift register that matches the SRAM read latency.
//
// Ports
//   Clock, Resetn      system clock (rising edge), asynchronous active-low reset
//   req                per-requester access request
//   req_we_n           per-requester write enable, active-low
//   req_addr           packed 18-bit addresses, requester i at [18i+17:18i]
//   req_wdata          packed 16-bit write data, requester i at [16i+15:16i]
//   gnt                one-hot/zero, access accepted this cycle (combinational)
//   rd_valid           one-hot/zero, rd_data belongs to that requester
//   rd_data            SRAM_read_data forwarded unregistered
//   SRAM_read_data     SRAM read bus
//   SRAM_address       registered SRAM address
//   SRAM_we_n          registered SRAM write enable, active-low
//   SRAM_write_data    registered SRAM write data
module sram_port_arbiter #(
  parameter int N_REQ        = 3,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 64
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_we_n,
  input  logic [N_REQ*18-1:0]   req_addr,
  input  logic [N_REQ*16-1:0]   req_wdata,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rd_valid,
  output logic [15:0]           rd_data,
  input  logic [15:0]           SRAM_read_data,
  output logic [17:0]           SRAM_address,
  output logic                  SRAM_we_n,
  output logic [15:0]           SRAM_write_data
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_OWNED = 1'b1;

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  // Cyclic successor of a requester id.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(N_REQ - 1)) begin
      return {ID_W{1'b0}};
    end else begin
      return id + ID_W'(1);
    end
  endfunction

  // First set bit of r at or after ptr, searching cyclically.
  // The result is {found, id}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0] res;
    int            idx;
    res = {(ID_W+1){1'b0}};
    // Walk from the far end back toward ptr, so the closest candidate wins last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (r[idx]) begin
        res = {1'b1, ID_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [0:0]        state_r;
  logic [ID_W-1:0]   owner_r;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [CNT_W-1:0]  burst_cnt_r;
  logic [N_REQ-1:0]  tag_r [READ_LATENCY+1];

  logic [0:0]        state_nxt_s;
  logic [ID_W-1:0]   owner_nxt_s;
  logic [ID_W-1:0]   rr_ptr_nxt_s;
  logic [CNT_W-1:0]  burst_cnt_nxt_s;
  logic              gnt_vld_s;
  logic [ID_W-1:0]   gnt_id_s;
  logic [ID_W:0]     pick_s;
  logic [N_REQ-1:0]  others_s;
  logic [N_REQ-1:0]  gnt_s;

  // Requesters other than the current owner that are waiting.
  always_comb begin
    others_s = req & ~(N_REQ'(1) << owner_r);
  end

  // Arbitration: grant decision and next ownership, pointer and burst count.
  always_comb begin
    state_nxt_s     = state_r;
    owner_nxt_s     = owner_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    burst_cnt_nxt_s = burst_cnt_r;
    gnt_vld_s       = 1'b0;
    gnt_id_s        = owner_r;
    pick_s          = {(ID_W+1){1'b0}};
    case (state_r)
      ARB_IDLE: begin
        pick_s = rr_pick(req, rr_ptr_r);
        if (pick_s[ID_W]) begin
          gnt_vld_s       = 1'b1;
          gnt_id_s        = pick_s[ID_W-1:0];
          state_nxt_s     = ARB_OWNED;
          owner_nxt_s     = pick_s[ID_W-1:0];
          burst_cnt_nxt_s = CNT_W'(1);
        end else begin
          state_nxt_s     = ARB_IDLE;
        end
      end
      ARB_OWNED: begin
        if (req[owner_r]) begin
          gnt_vld_s = 1'b1;
          gnt_id_s  = owner_r;
          if ((burst_cnt_r >= BURST_LAST) && (|others_s)) begin
            // This is the owner's last grant. The waiting requester takes over next cycle.
            pick_s          = rr_pick(others_s, next_id(owner_r));
            owner_nxt_s     = pick_s[ID_W-1:0];
            rr_ptr_nxt_s    = next_id(owner_r);
            burst_cnt_nxt_s = {CNT_W{1'b0}};
          end else if (burst_cnt_r < BURST_LAST) begin
            burst_cnt_nxt_s = burst_cnt_r + CNT_W'(1);
          end else begin
            // The owner is alone, so the count saturates and the owner keeps the port.
            burst_cnt_nxt_s = burst_cnt_r;
          end
        end else begin
          // The owner has released the port. Re-arbitrate in the same cycle so there is no bubble.
          rr_ptr_nxt_s = next_id(owner_r);
          pick_s       = rr_pick(req, next_id(owner_r));
          if (pick_s[ID_W]) begin
            gnt_vld_s       = 1'b1;
            gnt_id_s        = pick_s[ID_W-1:0];
            owner_nxt_s     = pick_s[ID_W-1:0];
            burst_cnt_nxt_s = CNT_W'(1);
          end else begin
            state_nxt_s     = ARB_IDLE;
            burst_cnt_nxt_s = {CNT_W{1'b0}};
          end
        end
      end
      default: begin
        state_nxt_s     = ARB_IDLE;
        burst_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // One-hot grant vector.
  always_comb begin
    if (gnt_vld_s) begin
      gnt_s = N_REQ'(1) << gnt_id_s;
    end else begin
      gnt_s = {N_REQ{1'b0}};
    end
  end

  assign gnt     = gnt_s;
  assign rd_data = SRAM_read_data;
  assign rd_valid = tag_r[READ_LATENCY];

  // Arbiter state registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r     <= ARB_IDLE;
      owner_r     <= {ID_W{1'b0}};
      rr_ptr_r    <= {ID_W{1'b0}};
      burst_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      owner_r     <= owner_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
    end
  end

  // SRAM command register. Address and data hold their value when there is no grant.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      SRAM_address    <= 18'h00000;
      SRAM_write_data <= 16'h0000;
      SRAM_we_n       <= 1'b1;
    end else if (gnt_vld_s) begin
      SRAM_address    <= req_addr[int'(gnt_id_s)*18 +: 18];
      SRAM_write_data <= req_wdata[int'(gnt_id_s)*16 +: 16];
      SRAM_we_n       <= req_we_n[gnt_id_s];
    end else begin
      SRAM_we_n       <= 1'b1;
    end
  end

  // Read-tag shift register. Each stage holds a one-hot owner id, or zero for a write or an idle cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int s = 0; s <= READ_LATENCY; s++) begin
        tag_r[s] <= {N_REQ{1'b0}};
      end
    end else begin
      if (gnt_vld_s && req_we_n[gnt_id_s]) begin
        tag_r[0] <= gnt_s;
      end else begin
        tag_r[0] <= {N_REQ{1'b0}};
      end
      for (int s = 1; s <= READ_LATENCY; s++) begin
        tag_r[s] <= tag_r[s-1];
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Directed and randomized stimulus for sram_port_arbiter. An arbitration and
//   read-return reference model runs inside the bench, and a function-of-address
//   SRAM model with two cycles of read latency drives SRAM_read_data.
module tb_sram_port_arbiter;

  localparam int N    = 3;
  localparam int MAXB = 64;

  logic          Clock = 1'b0;
  logic          Resetn;
  logic [2:0]    req, req_we_n, gnt, rd_valid;
  logic [53:0]   req_addr;
  logic [47:0]   req_wdata;
  logic [15:0]   rd_data, SRAM_read_data, SRAM_write_data;
  logic [17:0]   SRAM_address;
  logic          SRAM_we_n;

  sram_port_arbiter #(.N_REQ(3), .READ_LATENCY(2), .MAX_BURST(64)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .req_we_n(req_we_n),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .SRAM_read_data(SRAM_read_data), .SRAM_address(SRAM_address),
    .SRAM_we_n(SRAM_we_n), .SRAM_write_data(SRAM_write_data)
  );

  always #5 Clock = ~Clock;

  function automatic logic [15:0] sram_fn(input logic [17:0] a);
    return a[15:0] ^ 16'h5A3C ^ {14'h0000, a[17:16]};
  endfunction

  // SRAM model. Data appears two cycles after the registered address.
  logic [17:0] a1;
  always @(posedge Clock) begin
    a1             <= SRAM_address;
    SRAM_read_data <= sram_fn(a1);
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Requester-side stimulus state
  logic [2:0]  r_req, r_we;
  logic [17:0] r_addr [3];
  logic [15:0] r_data [3];

  // Reference model
  typedef struct { int cyc; int id; logic [17:0] addr; } ret_t;
  ret_t        rq[$];
  int          m_owner = -1, m_next = -1, m_run = 0, m_ptr = 0, cyc = 0, last_g = -1;
  logic [17:0] exp_addr = 18'h00000;
  logic [15:0] exp_data = 16'h0000;
  logic        exp_we   = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    req      = r_req;
    req_we_n = r_we;
    for (int i = 0; i < N; i++) begin
      req_addr[18*i +: 18]  = r_addr[i];
      req_wdata[16*i +: 16] = r_data[i];
    end
  endtask

  task automatic rand_fields(input int i);
    r_we[i]   = 1'($urandom % 2);
    r_addr[i] = 18'($urandom);
    r_data[i] = 16'($urandom);
  endtask

  // Rules: the owner keeps the port while requesting. At 64 grants with someone
  // waiting, the next waiting requester after the owner takes over. When the owner
  // releases, the pointer moves past it and a new owner is picked at once.
  task automatic model_step(output int g);
    bit found;
    g = -1;
    if (m_next >= 0) begin
      m_owner = m_next;
      m_next  = -1;
      m_run   = 0;
    end
    if (m_owner >= 0 && r_req[m_owner]) begin
      g = m_owner;
      m_run++;
      if (m_run >= MAXB) begin
        found = 1'b0;
        for (int k = 1; k < N; k++) begin
          if (!found && r_req[(m_owner + k) % N]) begin
            found  = 1'b1;
            m_next = (m_owner + k) % N;
          end
        end
        if (found) m_ptr = (m_owner + 1) % N;
      end
    end else begin
      if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
      m_owner = -1;
      m_run   = 0;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && r_req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) begin
        m_owner = g;
        m_run   = 1;
      end
    end
  endtask

  // One clock cycle: drive, check gnt, clock, then check registered outputs and read returns.
  task automatic step();
    int          g;
    logic [2:0]  eg, erv;
    logic [15:0] ed;
    apply();
    #1;
    model_step(g);
    last_g = g;
    eg = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk("gnt", 32'(gnt), 32'(eg));
    if (g >= 0) begin
      exp_addr = r_addr[g];
      exp_data = r_data[g];
      exp_we   = r_we[g];
      if (r_we[g]) rq.push_back('{cyc + 3, g, r_addr[g]});
    end else begin
      exp_we = 1'b1;
    end
    @(posedge Clock);
    cyc++;
    #1;
    chk("we_n", 32'(SRAM_we_n), 32'(exp_we));
    chk("addr", 32'(SRAM_address), 32'(exp_addr));
    chk("wdata", 32'(SRAM_write_data), 32'(exp_data));
    erv = 3'b000;
    ed  = 16'h0000;
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      erv = 3'(1 << rq[0].id);
      ed  = sram_fn(rq[0].addr);
      void'(rq.pop_front());
    end
    chk("rd_valid", 32'(rd_valid), 32'(erv));
    if (erv != 3'b000) chk("rd_data", 32'(rd_data), 32'(ed));
  endtask

  task automatic rand_update(input int keep_pct);
    for (int i = 0; i < N; i++) begin
      if (last_g == i) begin
        r_req[i] = ($urandom_range(0, 99) < keep_pct);
        rand_fields(i);
      end else if (!r_req[i]) begin
        r_req[i] = (($urandom % 3) == 0);
        rand_fields(i);
      end
    end
  endtask

  task automatic set_req(input int i, input logic rd, input logic [17:0] a, input logic [15:0] d);
    r_req[i]  = 1'b1;
    r_we[i]   = rd;
    r_addr[i] = a;
    r_data[i] = d;
  endtask

  initial begin
    r_req = 3'b000;
    r_we  = 3'b111;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = 18'h00000;
      r_data[i] = 16'h0000;
    end
    apply();
    Resetn = 1'b0;
    #12;
    chk("rst_we_n", 32'(SRAM_we_n), 32'h1);
    chk("rst_addr", 32'(SRAM_address), 32'h0);
    chk("rst_wdata", 32'(SRAM_write_data), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    #4;
    Resetn = 1'b1;

    // Idle after reset
    for (int c = 0; c < 5; c++) step();

    // All three read continuously. Each owner should hold for exactly MAXB cycles.
    r_req = 3'b111;
    r_we  = 3'b111;
    for (int k = 0; k < 3 * MAXB; k++) begin
      step();
      chk("burst_owner", 32'(last_g), 32'(k / MAXB));
      if (last_g >= 0) r_addr[last_g] = 18'($urandom);
    end
    r_req = 3'b000;
    for (int c = 0; c < 4; c++) step();

    // Back-to-back reads from two owners return in issue order.
    set_req(0, 1'b1, 18'h00010, 16'h0000);
    step();
    chk("t3_gnt0", 32'(last_g), 32'h0);
    r_req = 3'b000;
    set_req(1, 1'b1, 18'h00020, 16'h0000);
    step();
    chk("t3_gnt1", 32'(last_g), 32'h1);
    r_req = 3'b000;
    for (int c = 0; c < 4; c++) step();

    // A single write at the top address.
    set_req(2, 1'b0, 18'h3FFFF, 16'hBEEF);
    step();
    chk("t4_addr", 32'(SRAM_address), 32'h3FFFF);
    chk("t4_wdata", 32'(SRAM_write_data), 32'hBEEF);
    chk("t4_we_n", 32'(SRAM_we_n), 32'h0);
    r_req = 3'b000;
    step();
    chk("t4_we_n_after", 32'(SRAM_we_n), 32'h1);
    chk("t4_rd_valid", 32'(rd_valid), 32'h0);

    // Owner 1 releases while requester 0 waits.
    set_req(1, 1'b1, 18'h00100, 16'h0000);
    step();
    r_addr[1] = 18'h00101;
    step();
    set_req(0, 1'b1, 18'h00200, 16'h0000);
    step();
    chk("t5_hold1", 32'(last_g), 32'h1);
    r_req[1] = 1'b0;
    step();
    chk("t5_gnt0", 32'(last_g), 32'h0);
    // Move ownership to 1 again, then release with 0 and 2 waiting. The pointer should now be 2.
    r_req = 3'b000;
    set_req(1, 1'b1, 18'h00300, 16'h0000);
    step();
    chk("t5_gnt1b", 32'(last_g), 32'h1);
    set_req(0, 1'b1, 18'h00400, 16'h0000);
    set_req(2, 1'b1, 18'h00500, 16'h0000);
    r_req[1] = 1'b0;
    step();
    chk("t5_ptr2", 32'(last_g), 32'h2);
    r_req = 3'b000;
    for (int c = 0; c < 4; c++) step();

    // Reset with two reads in flight and a write on the bus.
    set_req(0, 1'b1, 18'h00600, 16'h0000);
    step();
    r_req = 3'b000;
    set_req(1, 1'b1, 18'h00700, 16'h0000);
    step();
    r_we[1]   = 1'b0;
    r_data[1] = 16'h1234;
    step();
    chk("t6_we_before", 32'(SRAM_we_n), 32'h0);
    Resetn = 1'b0;
    #1;
    chk("t6_we_async", 32'(SRAM_we_n), 32'h1);
    rq.delete();
    m_owner = -1; m_next = -1; m_run = 0; m_ptr = 0;
    exp_we = 1'b1; exp_addr = 18'h00000; exp_data = 16'h0000;
    r_req = 3'b000;
    apply();
    for (int c = 0; c < 2; c++) begin
      @(posedge Clock);
      cyc++;
      #1;
      chk("t6_rd_valid_rst", 32'(rd_valid), 32'h0);
    end
    Resetn = 1'b1;
    for (int c = 0; c < 4; c++) step();
    r_req = 3'b111;
    r_we  = 3'b111;
    step();
    chk("t6_restart0", 32'(last_g), 32'h0);
    r_req = 3'b000;
    for (int c = 0; c < 4; c++) step();

    // Randomized traffic: short bursts, then long sticky bursts that hit the cap.
    for (int i = 0; i < N; i++) rand_fields(i);
    for (int c = 0; c < 2000; c++) begin
      step();
      rand_update(75);
    end
    for (int c = 0; c < 3000; c++) begin
      step();
      rand_update(99);
    end
    r_req = 3'b000;
    for (int c = 0; c < 5; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
